// File: rtl/ren_tile_binner_pkg.sv
// Shared widths, record field offsets and binner state encoding for the tile binner.
// The optional step clamp is enabled with the REN_BINNER_STEP_CLAMP_EN macro.
package ren_tile_binner_pkg;

  localparam int FP_W      = 22;
  localparam int TRI_W     = 506;
  localparam int STEP_W    = 16;
  localparam int TRI_ID_W  = 8;
  localparam int TILE_SIZE = 16;

  localparam logic [STEP_W-1:0] MAX_STEPS_X = 16'd79;
  localparam logic [STEP_W-1:0] MAX_STEPS_Y = 16'd59;

  // Record is packed MSB first: 9 edge coeffs, min_x, min_y, then 12 attribute coeffs.
  localparam int EDGE_LSB  = TRI_W - 9 * FP_W;
  localparam int MIN_X_LSB = EDGE_LSB - FP_W;
  localparam int MIN_Y_LSB = MIN_X_LSB - FP_W;
  localparam int ATTR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DROP = 2'd2
  } binner_state_e;

  function automatic logic [STEP_W-1:0] clamp_steps(input logic [STEP_W-1:0] steps,
                                                    input logic [STEP_W-1:0] limit);
    return (steps > limit) ? limit : steps;
  endfunction

endpackage

// File: rtl/ren_tile_walker.sv
// Row-major tile walker: dx inner, dy outer, advancing one tile per accepted token.
module ren_tile_walker
  import ren_tile_binner_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_clear,
  input  logic              i_active,
  input  logic              i_advance,
  input  logic [STEP_W-1:0] i_sx,
  input  logic [STEP_W-1:0] i_sy,
  output logic [STEP_W-1:0] o_dx,
  output logic [STEP_W-1:0] o_dy,
  output logic              o_first,
  output logic              o_last,
  output logic              o_done
);

  logic [STEP_W-1:0] r_dx;
  logic [STEP_W-1:0] r_dy;
  logic              w_end_x;
  logic              w_end_y;

  assign w_end_x = (r_dx == i_sx);
  assign w_end_y = (r_dy == i_sy);

  // The last accept leaves dy at sy; the next capture clears both counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dx <= '0;
      r_dy <= '0;
    end else if (i_clear) begin
      r_dx <= '0;
      r_dy <= '0;
    end else if (i_advance) begin
      if (w_end_x) begin
        r_dx <= '0;
        if (!w_end_y) begin
          r_dy <= r_dy + 16'd1;
        end
      end else begin
        r_dx <= r_dx + 16'd1;
      end
    end
  end

  assign o_dx    = r_dx;
  assign o_dy    = r_dy;
  assign o_first = i_active & (r_dx == '0) & (r_dy == '0);
  assign o_last  = i_active & w_end_x & w_end_y;
  assign o_done  = i_advance & w_end_x & w_end_y;

endmodule

// File: rtl/ren_tile_binner.sv
// Tile binner: captures one setup record, then emits its bounding-box tiles row-major.
// Define REN_BINNER_STEP_CLAMP_EN to clamp the step counts to the screen on capture.
module ren_tile_binner
  import ren_tile_binner_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_valid,
  output logic                o_busy,
  input  logic [TRI_W-1:0]    i_tri_data,
  input  logic [STEP_W-1:0]   i_steps_x,
  input  logic [STEP_W-1:0]   i_steps_y,
  output logic                o_tile_valid,
  input  logic                i_tile_ready,
  output logic [TRI_W-1:0]    o_tri_data,
  output logic [STEP_W-1:0]   o_tile_dx,
  output logic [STEP_W-1:0]   o_tile_dy,
  output logic [TRI_ID_W-1:0] o_tri_id,
  output logic                o_first,
  output logic                o_last,
  output logic [STEP_W-1:0]   o_drop_cnt
);

  binner_state_e       r_state;
  binner_state_e       w_next;
  logic [TRI_W-1:0]    r_tri_data;
  logic [STEP_W-1:0]   r_sx;
  logic [STEP_W-1:0]   r_sy;
  logic [TRI_ID_W-1:0] r_tri_id;
  logic [STEP_W-1:0]   r_drop_cnt;
  logic                w_capture;
  logic                w_degenerate;
  logic                w_walking;
  logic                w_advance;
  logic                w_done;
  logic                w_bump_id;
  logic [STEP_W-1:0]   w_sx;
  logic [STEP_W-1:0]   w_sy;

  // A set sign bit means max < min in setup, so the record carries no tiles.
  assign w_degenerate = i_steps_x[STEP_W-1] | i_steps_y[STEP_W-1];

`ifdef REN_BINNER_STEP_CLAMP_EN
  assign w_sx = clamp_steps(i_steps_x, MAX_STEPS_X);
  assign w_sy = clamp_steps(i_steps_y, MAX_STEPS_Y);
`else
  assign w_sx = i_steps_x;
  assign w_sy = i_steps_y;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_walking    = 1'b0;
    w_advance    = 1'b0;
    w_bump_id    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_capture = 1'b1;
          w_next    = w_degenerate ? ST_DROP : ST_WALK;
        end
      end
      ST_WALK: begin
        w_walking = 1'b1;
        w_advance = i_tile_ready;
        if (w_done) begin
          w_bump_id = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_DROP: begin
        w_bump_id = 1'b1;
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tri_data <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
    end else if (w_capture) begin
      r_tri_data <= i_tri_data;
      r_sx       <= w_sx;
      r_sy       <= w_sy;
    end
  end

  // Triangle ids count both walked and dropped records so downstream can spot gaps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tri_id   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_bump_id) begin
        r_tri_id <= r_tri_id + 8'd1;
      end
      if ((r_state == ST_DROP) && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  ren_tile_walker u_walker (
    .clk       (clk),
    .rstn      (rstn),
    .i_clear   (w_capture),
    .i_active  (w_walking),
    .i_advance (w_advance),
    .i_sx      (r_sx),
    .i_sy      (r_sy),
    .o_dx      (o_tile_dx),
    .o_dy      (o_tile_dy),
    .o_first   (o_first),
    .o_last    (o_last),
    .o_done    (w_done)
  );

  assign o_busy       = (r_state != ST_IDLE);
  assign o_tile_valid = w_walking;
  assign o_tri_data   = r_tri_data;
  assign o_tri_id     = r_tri_id;
  assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_ren_tile_binner.sv
// Directed bench for ren_tile_binner: reset, drop, small walks, stalls, large walk, mid-walk reset.
module tb_ren_tile_binner;
  import ren_tile_binner_pkg::*;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                i_valid = 1'b0;
  logic                i_tile_ready = 1'b0;
  logic [TRI_W-1:0]    i_tri_data = '0;
  logic [15:0]         i_steps_x = '0;
  logic [15:0]         i_steps_y = '0;
  logic                o_busy;
  logic                o_tile_valid;
  logic [TRI_W-1:0]    o_tri_data;
  logic [15:0]         o_tile_dx;
  logic [15:0]         o_tile_dy;
  logic [7:0]          o_tri_id;
  logic                o_first;
  logic                o_last;
  logic [15:0]         o_drop_cnt;

  int nChecks = 0;
  int nPass = 0;

`ifdef REN_BINNER_STEP_CLAMP_EN
  localparam logic [15:0] BIG_SX = 16'd79;
`else
  localparam logic [15:0] BIG_SX = 16'd200;
`endif

  always #5 clk = ~clk;

  ren_tile_binner dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_valid      (i_valid),
    .o_busy       (o_busy),
    .i_tri_data   (i_tri_data),
    .i_steps_x    (i_steps_x),
    .i_steps_y    (i_steps_y),
    .o_tile_valid (o_tile_valid),
    .i_tile_ready (i_tile_ready),
    .o_tri_data   (o_tri_data),
    .o_tile_dx    (o_tile_dx),
    .o_tile_dy    (o_tile_dy),
    .o_tri_id     (o_tri_id),
    .o_first      (o_first),
    .o_last       (o_last),
    .o_drop_cnt   (o_drop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [TRI_W-1:0] makeRecord();
    logic [TRI_W-1:0] r;
    for (int i = 0; i < TRI_W; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  // Waits for idle, then presents one record for exactly one clock edge.
  task automatic applyStimulus(input logic [15:0] sx, input logic [15:0] sy,
                               input logic [TRI_W-1:0] d);
    int cyc = 0;
    while (o_busy && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("idle_before_capture", {511'd0, o_busy}, 512'd0);
    i_valid = 1'b1;
    i_tri_data = d;
    i_steps_x = sx;
    i_steps_y = sy;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  // readyMode 0: ready always high; 1: ready pattern 1,0,0,1 repeating.
  task automatic runWalk(input string tag, input logic [15:0] sx, input logic [15:0] sy,
                         input int readyMode, input int expTokens);
    int ex = 0, ey = 0, tokens = 0, seqErr = 0, stabErr = 0, maxDx = 0, cyc = 0;
    bit done = 0, held = 0;
    logic [15:0] hdx = '0, hdy = '0;
    logic hfirst = 1'b0, hlast = 1'b0;
    while (!done && cyc < 3000) begin
      i_tile_ready = (readyMode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (o_tile_valid) begin
        if (held && (o_tile_dx !== hdx || o_tile_dy !== hdy || o_first !== hfirst || o_last !== hlast))
          stabErr++;
        if (o_tile_dx !== 16'(ex) || o_tile_dy !== 16'(ey) ||
            o_first !== (ex == 0 && ey == 0) || o_last !== (16'(ex) == sx && 16'(ey) == sy))
          seqErr++;
        if (i_tile_ready) begin
          tokens++;
          held = 0;
          if (ex > maxDx) maxDx = ex;
          if (16'(ex) == sx) begin
            ex = 0;
            if (16'(ey) == sy) done = 1;
            else ey++;
          end else begin
            ex++;
          end
        end else begin
          held = 1;
          hdx = o_tile_dx; hdy = o_tile_dy; hfirst = o_first; hlast = o_last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_tile_ready = 1'b0;
    checkOutput({tag, "_done"}, {511'd0, done}, 512'd1);
    checkOutput({tag, "_tokens"}, 512'(tokens), 512'(expTokens));
    checkOutput({tag, "_seq_err"}, 512'(seqErr), 512'd0);
    checkOutput({tag, "_stable_err"}, 512'(stabErr), 512'd0);
    checkOutput({tag, "_max_dx"}, 512'(maxDx), 512'(sx));
    checkOutput({tag, "_busy_after"}, {511'd0, o_busy}, 512'd0);
  endtask

  initial begin
    logic [TRI_W-1:0] d;
    #12;
    checkOutput("rst_busy", {511'd0, o_busy}, 512'd0);
    checkOutput("rst_valid", {511'd0, o_tile_valid}, 512'd0);
    checkOutput("rst_first_last", {510'd0, o_first, o_last}, 512'd0);
    checkOutput("rst_dx_dy", {480'd0, o_tile_dx, o_tile_dy}, 512'd0);
    checkOutput("rst_tri_id", {504'd0, o_tri_id}, 512'd0);
    checkOutput("rst_drop_cnt", {496'd0, o_drop_cnt}, 512'd0);
    checkOutput("rst_tri_data", {6'd0, o_tri_data}, 512'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] degenerate record");
    applyStimulus(16'hFFFE, 16'd3, makeRecord());
    checkOutput("drop_busy", {511'd0, o_busy}, 512'd1);
    checkOutput("drop_no_token", {511'd0, o_tile_valid}, 512'd0);
    @(posedge clk); #1;
    checkOutput("drop_valid_after", {511'd0, o_tile_valid}, 512'd0);
    checkOutput("drop_busy_after", {511'd0, o_busy}, 512'd0);
    checkOutput("drop_cnt", {496'd0, o_drop_cnt}, 512'd1);
    checkOutput("drop_tri_id", {504'd0, o_tri_id}, 512'd1);

    $display("[TB] steps 0/0");
    d = makeRecord();
    applyStimulus(16'd0, 16'd0, d);
    checkOutput("s00_busy", {511'd0, o_busy}, 512'd1);
    checkOutput("s00_first_latency", {511'd0, o_tile_valid}, 512'd1);
    checkOutput("s00_tri_data", {6'd0, o_tri_data}, {6'd0, d});
    runWalk("s00", 16'd0, 16'd0, 0, 1);
    checkOutput("s00_tri_id", {504'd0, o_tri_id}, 512'd2);

    $display("[TB] steps 2/1");
    applyStimulus(16'd2, 16'd1, makeRecord());
    runWalk("s21", 16'd2, 16'd1, 0, 6);
    checkOutput("s21_tri_id", {504'd0, o_tri_id}, 512'd3);

    $display("[TB] steps 1/1 with stalls");
    d = makeRecord();
    applyStimulus(16'd1, 16'd1, d);
    runWalk("s11", 16'd1, 16'd1, 1, 4);
    checkOutput("s11_tri_id", {504'd0, o_tri_id}, 512'd4);
    checkOutput("s11_tri_data", {6'd0, o_tri_data}, {6'd0, d});

    $display("[TB] steps 200/3");
    applyStimulus(16'd200, 16'd3, makeRecord());
    runWalk("s200", BIG_SX, 16'd3, 0, (int'(BIG_SX) + 1) * 4);
    checkOutput("s200_tri_id", {504'd0, o_tri_id}, 512'd5);
    checkOutput("s200_drop_cnt", {496'd0, o_drop_cnt}, 512'd1);

    $display("[TB] reset mid-walk");
    applyStimulus(16'd2, 16'd2, makeRecord());
    i_tile_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rw_third_dx", {496'd0, o_tile_dx}, 512'd2);
    rstn = 1'b0;
    #1;
    checkOutput("rw_valid", {511'd0, o_tile_valid}, 512'd0);
    checkOutput("rw_busy", {511'd0, o_busy}, 512'd0);
    checkOutput("rw_tri_id", {504'd0, o_tri_id}, 512'd0);
    checkOutput("rw_drop_cnt", {496'd0, o_drop_cnt}, 512'd0);
    i_tile_ready = 1'b0;
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'd1, 16'd0, makeRecord());
    runWalk("post_rst", 16'd1, 16'd0, 0, 2);
    checkOutput("post_rst_tri_id", {504'd0, o_tri_id}, 512'd1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
